// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage of the LEGLite pipeline. Takes the PC from the PC
//   logic, issues word requests to instruction memory over a req/ack
//   handshake and loads returned instructions into the IF/ID register.
//   Handles decode back-pressure (id_stall) and branch flushes (flush).
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   pc           address of next instruction to fetch (from PC logic)
//   pc_stall     1 = PC logic must hold pc at this edge (combinational)
//   imem_req     memory request (registered)
//   imem_addr    request address (registered, stable until ack)
//   imem_ack     imem_rdata valid; only honoured while imem_req=1
//   imem_rdata   instruction word from memory
//   id_stall     decode cannot accept a new IF/ID value
//   flush        taken branch resolved this cycle
//   if_id_instr  IF/ID instruction
//   if_id_pc     IF/ID address of if_id_instr
//   if_id_valid  IF/ID holds a real instruction
//
// States
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | out of reset, no request; takes the first pc
//   FETCH    | request outstanding at fetch_pc, waiting for ack
//   HOLD     | ack data parked in hold_instr while decode is stalled
//   REDIRECT | one idle cycle so pc settles on the branch target
module if_fetch_stage #(
  parameter int                 INSTR_W = 32,
  parameter int                 ADDR_W  = 16,
  parameter logic [INSTR_W-1:0] BUBBLE  = 32'hD503201F
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               flush,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               discard, discard_nxt;
  logic               take;
  logic               load_hold;
  logic [INSTR_W-1:0] instr_nxt;
  logic [ADDR_W-1:0]  id_pc_nxt;
  logic               valid_nxt;

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    take        = 1'b0;
    load_hold   = 1'b0;
    instr_nxt   = if_id_instr;
    id_pc_nxt   = if_id_pc;
    valid_nxt   = if_id_valid;

    case (state)
      S_IDLE: begin
        if (flush) begin
          state_nxt = S_REDIRECT;
        end else begin
          take      = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        if (imem_ack) begin
          if (discard) begin
            // response to a request that was in flight at a flush
            discard_nxt = 1'b0;
            state_nxt   = S_REDIRECT;
          end else if (flush) begin
            state_nxt = S_REDIRECT;
          end else if (id_stall) begin
            load_hold = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            instr_nxt = imem_rdata;
            id_pc_nxt = fetch_pc;
            valid_nxt = 1'b1;
            take      = 1'b1;
          end
        end else begin
          // the request cannot be withdrawn, so a flush only marks it stale
          if (flush) begin
            discard_nxt = 1'b1;
          end else if (!id_stall) begin
            instr_nxt = BUBBLE;
            valid_nxt = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (flush) begin
          state_nxt = S_REDIRECT;
        end else if (!id_stall) begin
          instr_nxt = hold_instr;
          id_pc_nxt = fetch_pc;
          valid_nxt = 1'b1;
          take      = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      S_REDIRECT: begin
        if (!flush) begin
          take      = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    if (flush) begin
      instr_nxt = BUBBLE;
      valid_nxt = 1'b0;
    end
  end

  // during a flush the PC logic must advance to load the branch target
  assign pc_stall  = ~(take | flush);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      fetch_pc    <= '0;
      hold_instr  <= BUBBLE;
      discard     <= 1'b0;
      imem_req    <= 1'b0;
      if_id_instr <= BUBBLE;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      discard     <= discard_nxt;
      imem_req    <= (state_nxt == S_FETCH);
      if_id_instr <= instr_nxt;
      if_id_pc    <= id_pc_nxt;
      if_id_valid <= valid_nxt;
      if (take) begin
        fetch_pc <= pc;
      end
      if (load_hold) begin
        hold_instr <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam logic [31:0] BUBBLE = 32'hD503201F;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc = 16'h0;
  logic        pc_stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 1;
  bit          mem_en  = 1'b1;
  int          cnt     = 0;
  logic [15:0] br_target = 16'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] addr;
  } exp_t;
  exp_t exp_q[$];

  if_fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_stall    (pc_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_stall    (id_stall),
    .flush       (flush),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  always #5 clock = ~clock;

  // memory: ack arrives lat-1 cycles after the request rises, rdata = addr + 0x1000
  initial forever begin
    @(posedge clock);
    if (!reset) cnt = 0;
    else if (imem_req) cnt = imem_ack ? 0 : cnt + 1;
    #2;
    if (mem_en) begin
      imem_ack   = imem_req && (cnt == lat - 1);
      imem_rdata = {16'h0, imem_addr} + 32'h1000;
    end
  end

  // PC logic: +4 when not stalled, branch target on flush
  initial begin : pc_model
    logic s, f;
    forever begin
      @(posedge clock);
      s = pc_stall;
      f = flush;
      #2;
      if (!reset) pc = 16'h0;
      else if (f) pc = br_target;
      else if (!s) pc = pc + 16'd4;
    end
  end

  // scoreboard monitor: a new IF/ID load is a valid entry that decode was not holding
  initial begin : monitor
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        pv = 1'b0;
      end else begin
        if (if_id_valid && (!pv || !id_stall)) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra_load: got instr=%h pc=%h, expected no load", if_id_instr, if_id_pc);
          end else begin
            e = exp_q.pop_front();
            if (e.instr !== if_id_instr || e.addr !== if_id_pc) begin
              n_fail++;
              $display("FAIL sb_load: got instr=%h pc=%h, expected instr=%h pc=%h",
                       if_id_instr, if_id_pc, e.instr, e.addr);
            end
          end
        end
        pv = if_id_valid;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [15:0] a);
    exp_q.push_back({i, a});
  endtask

  task automatic step();
    @(posedge clock);
    #3;
  endtask

  // reset for two edges, then release 3ns after an edge
  task automatic start(input int l);
    reset    = 1'b0;
    id_stall = 1'b0;
    flush    = 1'b0;
    mem_en   = 1'b1;
    step();
    step();
    lat   = l;
    reset = 1'b1;
  endtask

  initial begin
    step();
    chk("rst_req",   imem_req,    32'd0);
    chk("rst_addr",  imem_addr,   32'd0);
    chk("rst_instr", if_id_instr, BUBBLE);
    chk("rst_pc",    if_id_pc,    32'd0);
    chk("rst_valid", if_id_valid, 32'd0);

    // zero-wait memory, one instruction per cycle
    start(1);
    push(32'h1000, 16'h0); push(32'h1004, 16'h4); push(32'h1008, 16'h8);
    step();
    chk("a_req_e1",   imem_req,    32'd1);
    chk("a_addr_e1",  imem_addr,   32'd0);
    chk("a_valid_e1", if_id_valid, 32'd0);
    chk("a_stall_e1", pc_stall,    32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("a_valid", if_id_valid, 32'd1);
      chk("a_stall", pc_stall,    32'd0);
    end

    // 3-cycle latency
    start(3);
    push(32'h1000, 16'h0); push(32'h1004, 16'h4);
    step();
    chk("b_req_e1",   imem_req,  32'd1);
    chk("b_addr_e1",  imem_addr, 32'd0);
    chk("b_stall_e1", pc_stall,  32'd1);
    step();
    chk("b_addr_e2",  imem_addr, 32'd0);
    chk("b_stall_e2", pc_stall,  32'd1);
    step();
    chk("b_addr_e3",  imem_addr, 32'd0);
    chk("b_stall_e3", pc_stall,  32'd0);
    step();
    chk("b_valid_e4", if_id_valid, 32'd1);
    step();
    chk("b_valid_e5", if_id_valid, 32'd0);
    chk("b_instr_e5", if_id_instr, BUBBLE);
    chk("b_pc_e5",    if_id_pc,    32'd0);
    step();
    chk("b_valid_e6", if_id_valid, 32'd0);
    step();
    chk("b_valid_e7", if_id_valid, 32'd1);

    // decode stall while the 0x0008 ack returns
    start(1);
    push(32'h1000, 16'h0); push(32'h1004, 16'h4); push(32'h1008, 16'h8); push(32'h100C, 16'hC);
    step(); step(); step();
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("c_hold_req",   imem_req,    32'd0);
      chk("c_hold_instr", if_id_instr, 32'h1004);
      chk("c_hold_pc",    if_id_pc,    32'h4);
      chk("c_hold_valid", if_id_valid, 32'd1);
    end
    id_stall = 1'b0;
    step();
    chk("c_rel_instr", if_id_instr, 32'h1008);
    chk("c_rel_pc",    if_id_pc,    32'h8);
    chk("c_rel_valid", if_id_valid, 32'd1);
    chk("c_rel_req",   imem_req,    32'd1);
    chk("c_rel_addr",  imem_addr,   32'hC);
    step();

    // flush to 0x0040 while the 2-cycle request at 0x000C is outstanding
    start(2);
    push(32'h1000, 16'h0); push(32'h1004, 16'h4); push(32'h1008, 16'h8); push(32'h1040, 16'h40);
    repeat (7) step();
    br_target = 16'h40;
    flush     = 1'b1;
    #1;
    chk("d_flush_stall", pc_stall,  32'd0);
    chk("d_flush_addr",  imem_addr, 32'hC);
    step();
    flush = 1'b0;
    #1;
    chk("d_bub_valid", if_id_valid, 32'd0);
    chk("d_bub_instr", if_id_instr, BUBBLE);
    chk("d_bub_pc",    if_id_pc,    32'h8);
    chk("d_req_held",  imem_req,    32'd1);
    chk("d_addr_held", imem_addr,   32'hC);
    chk("d_disc_stall", pc_stall,   32'd1);
    step();
    chk("d_redir_req",   imem_req,    32'd0);
    chk("d_redir_valid", if_id_valid, 32'd0);
    chk("d_redir_stall", pc_stall,    32'd0);
    step();
    chk("d_tgt_req",  imem_req,  32'd1);
    chk("d_tgt_addr", imem_addr, 32'h40);
    step(); step();
    chk("d_tgt_pc", if_id_pc, 32'h40);

    // flush and id_stall together in HOLD
    start(1);
    push(32'h1000, 16'h0); push(32'h1080, 16'h80); push(32'h1084, 16'h84);
    step(); step();
    id_stall = 1'b1;
    step();
    chk("e_hold_req",   imem_req,    32'd0);
    chk("e_hold_instr", if_id_instr, 32'h1000);
    br_target = 16'h80;
    flush     = 1'b1;
    #1;
    chk("e_flush_stall", pc_stall, 32'd0);
    step();
    flush    = 1'b0;
    id_stall = 1'b0;
    #1;
    chk("e_bub_valid", if_id_valid, 32'd0);
    chk("e_bub_instr", if_id_instr, BUBBLE);
    chk("e_redir_req", imem_req,    32'd0);
    step();
    chk("e_tgt_req",  imem_req,  32'd1);
    chk("e_tgt_addr", imem_addr, 32'h80);
    step();
    chk("e_tgt_instr", if_id_instr, 32'h1080);
    step();

    // reset mid-FETCH with ack in the same cycle
    start(3);
    push(32'h1000, 16'h0);
    repeat (6) step();
    chk("f_pre_req",  imem_req,  32'd1);
    chk("f_pre_addr", imem_addr, 32'h4);
    mem_en   = 1'b0;
    imem_ack = 1'b1;
    reset    = 1'b0;
    #1;
    chk("f_rst_req",   imem_req,    32'd0);
    chk("f_rst_addr",  imem_addr,   32'd0);
    chk("f_rst_instr", if_id_instr, BUBBLE);
    chk("f_rst_pc",    if_id_pc,    32'd0);
    chk("f_rst_valid", if_id_valid, 32'd0);
    step(); step();
    chk("f_in_rst_valid", if_id_valid, 32'd0);
    chk("f_in_rst_instr", if_id_instr, BUBBLE);
    chk("f_in_rst_req",   imem_req,    32'd0);
    imem_ack = 1'b0;
    mem_en   = 1'b1;
    step();

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL sb_missing_load: got none, expected instr=%h pc=%h", e.instr, e.addr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
